display_scan_scheduler: RTL and testbench

- Time-multiplexes one shared hex-to-seven-segment decoder across NDIG common-anode digits.
- Inserts a blanking interval before each digit switch so no digit shows another digit's pattern (no ghosting).
- Applies 16-step PWM brightness per digit slot.
- Sits between the raw nibble inputs and the board anode/segment pins; replaces the free-running counter-bit select.

---
 rtl/display_scan_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_display_scan_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_scheduler.sv
// Scan scheduler for NDIG common-anode digits sharing one hex-to-7-segment decoder.
// Each digit dwell is a blanking gap followed by 16 PWM slots split between lit and dark.
module display_scan_scheduler #(
    parameter int NDIG      = 2,
    parameter int SLOT_CYC  = 1500,
    parameter int BLANK_CYC = 480
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [NDIG-1:0]           digit_en,
    input  logic [3:0]                bright,
    input  logic [4*NDIG-1:0]         data,
    output logic [3:0]                nib_sel,
    input  logic [6:0]                seg_in,
    output logic [6:0]                seg_out,
    output logic [NDIG-1:0]           an_n,
    output logic [$clog2(NDIG)-1:0]   digit_idx,
    output logic                      frame_done
);

    localparam int IW   = $clog2(NDIG);
    localparam int MAXC = (SLOT_CYC > BLANK_CYC) ? SLOT_CYC : BLANK_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, BLANK, ON, OFF} state_t;

    state_t            state_r, state_s;
    logic [CW-1:0]     cyc_r, cyc_s;
    logic [3:0]        slot_r, slot_s;
    logic [3:0]        bright_r, bright_s;
    logic [IW-1:0]     idx_r, idx_s;
    logic [3:0]        nib_r, nib_s;
    logic [6:0]        seg_r, seg_s;
    logic [NDIG-1:0]   an_r, an_s;
    logic              frame_r, frame_s;
    logic [IW:0]       nxt_s;
    logic              slot_end_s;

    function automatic logic [IW-1:0] lowest_enabled(input logic [NDIG-1:0] en_v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (en_v[i]) r = IW'(i);
            else         r = r;
        end
        return r;
    endfunction

    // Returns {found, index}: first enabled digit above cur, wrapping back onto cur itself.
    function automatic logic [IW:0] next_enabled(input logic [NDIG-1:0] en_v,
                                                 input logic [IW-1:0]   cur);
        logic [IW:0]   r;
        logic [IW-1:0] k;
        r = '0;
        for (int i = NDIG; i >= 1; i--) begin
            k = IW'((int'(cur) + i) % NDIG);
            if (en_v[k]) r = {1'b1, k};
            else         r = r;
        end
        return r;
    endfunction

    function automatic logic [3:0] pick_nibble(input logic [4*NDIG-1:0] d,
                                               input logic [IW-1:0]     k);
        logic [3:0] r;
        r = 4'd0;
        for (int j = 0; j < NDIG; j++) begin
            if (IW'(j) == k) r = d[4*j +: 4];
            else             r = r;
        end
        return r;
    endfunction

    assign slot_end_s = (cyc_r == CW'(SLOT_CYC - 1));

    // Next-state and next-output computation for the scan FSM.
    always_comb begin
        state_s  = state_r;
        cyc_s    = cyc_r + CW'(1);
        slot_s   = slot_r;
        bright_s = bright_r;
        idx_s    = idx_r;
        nib_s    = nib_r;
        seg_s    = seg_r;
        frame_s  = 1'b0;
        an_s     = {NDIG{1'b1}};
        nxt_s    = next_enabled(digit_en, idx_r);
        if (!en) begin
            state_s = IDLE;
            cyc_s   = '0;
            slot_s  = 4'd0;
            seg_s   = SEG_BLANK;
        end else begin
            case (state_r)
                IDLE: begin
                    cyc_s  = '0;
                    slot_s = 4'd0;
                    seg_s  = SEG_BLANK;
                    if (|digit_en) begin
                        state_s = BLANK;
                        idx_s   = lowest_enabled(digit_en);
                        nib_s   = pick_nibble(data, idx_s);
                    end else begin
                        state_s = IDLE;
                    end
                end
                BLANK: begin
                    nib_s = pick_nibble(data, idx_r);
                    if (cyc_r == CW'(BLANK_CYC - 1)) begin
                        cyc_s    = '0;
                        slot_s   = 4'd0;
                        bright_s = bright;
                        if (bright != 4'd0) begin
                            state_s = ON;
                            seg_s   = seg_in;
                        end else begin
                            state_s = OFF;
                            seg_s   = SEG_BLANK;
                        end
                    end else begin
                        state_s = BLANK;
                    end
                end
                ON: begin
                    if (slot_end_s) begin
                        cyc_s = '0;
                        if (slot_r == bright_r - 4'd1) begin
                            state_s = OFF;
                            slot_s  = 4'd0;
                            seg_s   = SEG_BLANK;
                        end else begin
                            slot_s = slot_r + 4'd1;
                        end
                    end else begin
                        slot_s = slot_r;
                    end
                end
                OFF: begin
                    if (slot_end_s) begin
                        cyc_s = '0;
                        if (slot_r == 4'd15 - bright_r) begin
                            slot_s = 4'd0;
                            if (nxt_s[IW]) begin
                                state_s = BLANK;
                                idx_s   = nxt_s[IW-1:0];
                                nib_s   = pick_nibble(data, idx_s);
                                frame_s = (idx_s <= idx_r) ? 1'b1 : 1'b0;
                            end else begin
                                state_s = IDLE;
                            end
                        end else begin
                            slot_s = slot_r + 4'd1;
                        end
                    end else begin
                        slot_s = slot_r;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cyc_s   = '0;
                    slot_s  = 4'd0;
                    seg_s   = SEG_BLANK;
                end
            endcase
        end
        // Anode decode follows the next state so the lit window lines up with ON exactly.
        if (state_s == ON) begin
            an_s = ~({{(NDIG-1){1'b0}}, 1'b1} << idx_s);
        end else begin
            an_s = {NDIG{1'b1}};
        end
    end

    // State and output registers; reset blanks the anodes asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            cyc_r    <= '0;
            slot_r   <= 4'd0;
            bright_r <= 4'd0;
            idx_r    <= '0;
            nib_r    <= 4'd0;
            seg_r    <= SEG_BLANK;
            an_r     <= {NDIG{1'b1}};
            frame_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            cyc_r    <= cyc_s;
            slot_r   <= slot_s;
            bright_r <= bright_s;
            idx_r    <= idx_s;
            nib_r    <= nib_s;
            seg_r    <= seg_s;
            an_r     <= an_s;
            frame_r  <= frame_s;
        end
    end

    assign nib_sel    = nib_r;
    assign seg_out    = seg_r;
    assign an_n       = an_r;
    assign digit_idx  = idx_r;
    assign frame_done = frame_r;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Directed bench for display_scan_scheduler with NDIG=2, SLOT_CYC=4, BLANK_CYC=2.
// Digit period is 2 + 16*4 = 66 cycles; a two-digit frame is 132 cycles.
module tb_display_scan_scheduler;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] digit_en;
    logic [3:0] bright;
    logic [7:0] data;
    logic [3:0] nib_sel;
    logic [6:0] seg_in;
    logic [6:0] seg_out;
    logic [1:0] an_n;
    logic       digit_idx;
    logic       frame_done;

    int total = 0;
    int bad   = 0;

    logic [1:0] prev_an;
    logic [6:0] prev_seg;
    logic       prev_ok = 1'b0;

    display_scan_scheduler #(.NDIG(2), .SLOT_CYC(4), .BLANK_CYC(2)) dut (
        .clk(clk), .reset(reset), .en(en), .digit_en(digit_en), .bright(bright),
        .data(data), .nib_sel(nib_sel), .seg_in(seg_in), .seg_out(seg_out),
        .an_n(an_n), .digit_idx(digit_idx), .frame_done(frame_done)
    );

    function automatic logic [6:0] seg_lut(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    assign seg_in = seg_lut(nib_sel);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global invariants: at most one anode low; segments stable across a lit edge.
    always @(negedge clk) begin
        if (reset) begin
            prev_ok = 1'b0;
        end else begin
            total++;
            if ((an_n == 2'b00) || (prev_ok && prev_an != 2'b11 && an_n != 2'b11 && seg_out !== prev_seg)) begin
                bad++;
                $display("FAIL invariant an_n=%b seg_out=%h prev_an=%b prev_seg=%h", an_n, seg_out, prev_an, prev_seg);
            end
            prev_an  = an_n;
            prev_seg = seg_out;
            prev_ok  = 1'b1;
        end
    end

    task automatic restart(input logic [1:0] de, input logic [3:0] br, input logic [7:0] d);
        en = 1'b0;
        @(negedge clk);
        digit_en = de;
        bright   = br;
        data     = d;
        en       = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; digit_en = 2'b11; bright = 4'd15; data = 8'h53;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (an_n !== 2'b11 || seg_out !== 7'h7F || frame_done !== 1'b0 || digit_idx !== 1'b0 || nib_sel !== 4'd0) begin
                bad++;
                $display("FAIL reset_hold an_n=%b seg=%h fd=%b idx=%b nib=%h exp 11/7f/0/0/0", an_n, seg_out, frame_done, digit_idx, nib_sel);
            end
        end
        @(posedge clk);
        #2;
        total++;
        if (an_n !== 2'b11 || seg_out !== 7'h7F || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_midclk an_n=%b seg=%h fd=%b exp 11/7f/0", an_n, seg_out, frame_done);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_full_bright();
        logic [1:0] ea; logic [6:0] es; logic ef; logic ei; int p;
        restart(2'b11, 4'd15, 8'h53);
        for (int c = 1; c <= 266; c++) begin
            @(negedge clk);
            p = (c - 1) % 132 + 1;
            ea = 2'b11; es = 7'h7F;
            if (p >= 3 && p <= 62)       begin ea = 2'b10; es = 7'h30; end
            else if (p >= 69 && p <= 128) begin ea = 2'b01; es = 7'h12; end
            ef = (p == 1 && c > 1);
            ei = (p >= 67);
            total++;
            if (an_n !== ea || seg_out !== es || frame_done !== ef || digit_idx !== ei) begin
                bad++;
                $display("FAIL full_bright c=%0d an_n=%b/%b seg=%h/%h fd=%b/%b idx=%b/%b", c, an_n, ea, seg_out, es, frame_done, ef, digit_idx, ei);
            end
        end
    endtask

    task automatic test_dark();
        logic ef; int p;
        restart(2'b11, 4'd0, 8'h53);
        for (int c = 1; c <= 266; c++) begin
            @(negedge clk);
            p = (c - 1) % 132 + 1;
            ef = (p == 1 && c > 1);
            total++;
            if (an_n !== 2'b11 || seg_out !== 7'h7F || frame_done !== ef) begin
                bad++;
                $display("FAIL dark c=%0d an_n=%b seg=%h fd=%b exp 11/7f/%b", c, an_n, seg_out, frame_done, ef);
            end
        end
    endtask

    task automatic test_single_digit();
        logic [1:0] ea; logic [6:0] es; logic ef; int p;
        restart(2'b10, 4'd8, 8'h53);
        for (int c = 1; c <= 133; c++) begin
            @(negedge clk);
            p = (c - 1) % 66 + 1;
            ea = 2'b11; es = 7'h7F;
            if (p >= 3 && p <= 34) begin ea = 2'b01; es = 7'h12; end
            ef = (p == 1 && c > 1);
            total++;
            if (an_n !== ea || seg_out !== es || frame_done !== ef || digit_idx !== 1'b1) begin
                bad++;
                $display("FAIL single c=%0d an_n=%b/%b seg=%h/%h fd=%b/%b idx=%b/1", c, an_n, ea, seg_out, es, frame_done, ef, digit_idx);
            end
        end
    endtask

    task automatic test_data_change();
        logic [6:0] es;
        restart(2'b11, 4'd15, 8'h53);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            es = 7'h7F;
            if (c >= 3 && c <= 62)        es = 7'h30;
            else if (c >= 69 && c <= 128) es = 7'h12;
            else if (c >= 135 && c <= 194) es = 7'h19;
            total++;
            if (seg_out !== es) begin
                bad++;
                $display("FAIL data_change c=%0d seg=%h exp %h", c, seg_out, es);
            end
            if (c == 11) begin
                total++;
                if (nib_sel !== 4'h3) begin
                    bad++;
                    $display("FAIL nib_hold_on nib_sel=%h exp 3", nib_sel);
                end
            end
            if (c == 10) data = 8'h54;
        end
    endtask

    task automatic test_en_drop();
        restart(2'b11, 4'd15, 8'h53);
        repeat (20) @(negedge clk);
        total++;
        if (an_n !== 2'b10) begin
            bad++;
            $display("FAIL en_drop_pre an_n=%b exp 10", an_n);
        end
        en = 1'b0;
        repeat (4) begin
            @(negedge clk);
            total++;
            if (an_n !== 2'b11 || seg_out !== 7'h7F || frame_done !== 1'b0) begin
                bad++;
                $display("FAIL en_drop_idle an_n=%b seg=%h fd=%b exp 11/7f/0", an_n, seg_out, frame_done);
            end
        end
        en = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            total++;
            if (an_n !== ((c == 3) ? 2'b10 : 2'b11) || digit_idx !== 1'b0) begin
                bad++;
                $display("FAIL en_restart c=%0d an_n=%b idx=%b exp %b/0", c, an_n, digit_idx, (c == 3) ? 2'b10 : 2'b11);
            end
        end
        total++;
        if (seg_out !== 7'h30) begin
            bad++;
            $display("FAIL en_restart_seg seg=%h exp 30", seg_out);
        end
    endtask

    task automatic test_reset_mid_on();
        restart(2'b11, 4'd15, 8'h53);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (an_n !== 2'b11 || seg_out !== 7'h7F || frame_done !== 1'b0 || nib_sel !== 4'd0) begin
            bad++;
            $display("FAIL reset_mid_on an_n=%b seg=%h fd=%b nib=%h exp 11/7f/0/0", an_n, seg_out, frame_done, nib_sel);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (an_n !== 2'b11 || nib_sel !== 4'h3 || digit_idx !== 1'b0) begin
            bad++;
            $display("FAIL reset_restart_blank an_n=%b nib=%h idx=%b exp 11/3/0", an_n, nib_sel, digit_idx);
        end
        repeat (2) @(negedge clk);
        total++;
        if (an_n !== 2'b10 || seg_out !== 7'h30) begin
            bad++;
            $display("FAIL reset_restart_on an_n=%b seg=%h exp 10/30", an_n, seg_out);
        end
    endtask

    initial begin
        test_reset();
        test_full_bright();
        test_dark();
        test_single_digit();
        test_data_change();
        test_en_drop();
        test_reset_mid_on();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
